enigma_ctrl: RTL and testbench
==============================

Name: enigma_ctrl

Overview:
Message-level controller that sequences the single-character cipher core, which has no backpressure and a 1-cycle latency. It accepts a length-prefixed message on a valid/ready input stream and issues one character at a time to the core. It captures each core result and presents it on a valid/ready output stream with a last-flag and a completion pulse. Codes outside 0..25 bypass the core, and missing core responses are caught by a watchdog.

Parameters:
LEN_W, 8, width of msg_len and the remaining-count register (max message 2^LEN_W-1 chars)
WAIT_MAX, 4, cycles allowed in WAIT for core_valid_out before timeout (min 1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin message; sampled only in IDLE
msg_len  in  LEN_W  character count, latched on accepted start
abort  in  1  synchronous abort, returns to IDLE from any state
in_valid  in  1  upstream character valid
in_char  in  5  upstream character code
in_ready  out  1  controller can take a character (FETCH only)
out_valid  out  1  result valid
out_char  out  5  result character
out_last  out  1  qualifies the final character of the message
out_ready  in  1  downstream accepts result
core_valid_in  out  1  to core valid_in
core_char_in  out  5  to core char_in
core_char_out  in  5  from core char_out
core_valid_out  in  1  from core valid_out
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse at message completion
err  out  1  sticky: bypass char or core timeout seen; cleared on accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0. Internal regs also clear: hold, result, rem, wait counter.
- States: IDLE, FETCH, ISSUE, WAIT, EMIT, DONE.
- IDLE: accepted start requires start=1.
  - msg_len!=0: latch rem=msg_len, clear err, go FETCH.
  - msg_len==0: clear err, go DONE, so done pulses the next cycle with no output.
- FETCH: in_ready=1. On in_valid&in_ready: hold<=in_char.
  - in_char<=25: go ISSUE.
  - in_char 26..31: result<=in_char, err<=1, go EMIT (core not used).
- ISSUE: core_valid_in=1 and core_char_in=hold for exactly one cycle. Clear the wait counter, go WAIT.
- WAIT: core_valid_in=0.
  - core_valid_out=1: result<=core_char_out, go EMIT.
  - Otherwise increment the counter. At count WAIT_MAX: result<=hold, err<=1, go EMIT.
- EMIT: out_valid=1, out_char=result, out_last=(rem==1). out_char and out_last are held stable while out_ready=0.
  - On out_ready: rem<=rem-1; go DONE if rem==1, else FETCH.
- DONE: done=1 for one cycle, go IDLE. busy drops the following cycle.
- core_char_in=hold whenever core_valid_in=0; its value is don't-care, but it must be driven and not X after reset.
- Latency (nominal core): input handshake in cycle T → core_valid_in in T+1 → core_valid_out in T+2 → out_valid in T+3.
  - Minimum 4 cycles per character with out_ready held 1.
- start while busy: ignored. in_valid outside FETCH: ignored (in_ready=0).
- abort=1 in any state: go IDLE next cycle, out_valid/core_valid_in deassert, no done pulse, err retained.
  - A core_valid_out arriving after abort is ignored.
  - abort has priority over start in the same cycle.
- Stray core_valid_out outside WAIT: ignored.
- rem arithmetic is unsigned LEN_W. msg_len=2^LEN_W-1 must complete without wrap.

Test Plan:
- Basic: start, msg_len=3, chars 0,7,25, out_ready=1 → out_char 1,8,0, out_last only on the 3rd, done 1 cycle after the 3rd handshake, err=0, out_valid exactly 3 cycles after each input handshake.
- Backpressure: msg_len=2, chars 4,5, out_ready low 5 cycles during the first EMIT → out_char=5 held stable, in_ready=0 throughout, then 5,6 delivered in order.
- Bypass: msg_len=2, chars 30,2 → out 30 then 3, core_valid_in pulses once only, err=1 until the next start.
- Timeout: core stub never asserts valid_out, WAIT_MAX=4, char 9 → out_char=9, err=1, out_valid appears 4 cycles into WAIT.
- Zero-length and start-while-busy: msg_len=0 → done pulse next cycle, no out_valid. A second start mid-message is ignored and the count is unchanged.
- Abort/reset mid-message: abort during WAIT → IDLE, no done, late core_valid_out ignored. rst low during EMIT → out_valid, busy, done, err all 0 immediately (async).

Source files
------------

// File: rtl/enigma_ctrl_if.sv
// Character streams between the message controller, its upstream/downstream and the cipher core.
// master = controller side; slave = everything the controller talks to.
interface enigma_ctrl_if;
  logic       in_valid;
  logic [4:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_last;
  logic       out_ready;
  logic       core_valid_in;
  logic [4:0] core_char_in;
  logic [4:0] core_char_out;
  logic       core_valid_out;

  modport master (
    input  in_valid, in_char, out_ready, core_char_out, core_valid_out,
    output in_ready, out_valid, out_char, out_last, core_valid_in, core_char_in
  );

  modport slave (
    output in_valid, in_char, out_ready, core_char_out, core_valid_out,
    input  in_ready, out_valid, out_char, out_last, core_valid_in, core_char_in
  );
endinterface

// File: rtl/enigma_ctrl.sv
// Message sequencer for the 1-cycle cipher core: one char in flight, 3 cycles input-to-output.
// Backpressure: in_ready only in FETCH; out_char/out_last hold while out_ready is low.
module enigma_ctrl #(
  parameter int LEN_W    = 8,
  parameter int WAIT_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  enigma_ctrl_if.master    bus
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);
  localparam logic [4:0] MAX_CODE = 5'd25;

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [4:0]       hold;
  logic [4:0]       result;
  logic [LEN_W-1:0] rem;
  logic [CNT_W-1:0] wcnt;
  logic             last_char;
  logic             timeout;

  assign last_char = (rem == LEN_W'(1));
  assign timeout   = (wcnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    bus.in_ready      = 1'b0;
    bus.out_valid     = 1'b0;
    bus.out_last      = 1'b0;
    bus.core_valid_in = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (msg_len == '0) ? DONE : FETCH;
      FETCH: begin
        // Refuse a character in the abort cycle so upstream never sees it consumed.
        bus.in_ready = !abort;
        if (bus.in_valid) state_nxt = (bus.in_char > MAX_CODE) ? EMIT : ISSUE;
      end
      ISSUE: begin
        bus.core_valid_in = 1'b1;
        state_nxt         = WAIT;
      end
      WAIT: if (bus.core_valid_out || timeout) state_nxt = EMIT;
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = last_char;
        if (bus.out_ready) state_nxt = last_char ? DONE : FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  assign bus.out_char     = result;
  assign bus.core_char_in = hold;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold   <= '0;
      result <= '0;
      rem    <= '0;
      wcnt   <= '0;
      err    <= 1'b0;
    end else if (!abort) begin
      case (state)
        IDLE: if (start) begin
          err <= 1'b0;
          rem <= msg_len;
        end
        FETCH: if (bus.in_valid) begin
          hold <= bus.in_char;
          // Codes the core cannot encipher pass straight through and flag the message.
          if (bus.in_char > MAX_CODE) begin
            result <= bus.in_char;
            err    <= 1'b1;
          end
        end
        ISSUE: wcnt <= '0;
        WAIT: begin
          if (bus.core_valid_out) begin
            result <= bus.core_char_out;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
            if (timeout) begin
              result <= hold;
              err    <= 1'b1;
            end
          end
        end
        EMIT: if (bus.out_ready) rem <= rem - LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_ctrl.sv
// Bench for enigma_ctrl: directed scenarios plus random messages against a per-character reference model.
module tb_enigma_ctrl;
  localparam int WAIT_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] msg_len = 8'd0;
  logic       busy, done, err;

  bit         core_en = 1'b1;
  bit         stray = 1'b0;
  logic [4:0] stray_char = 5'd0;
  logic       cvo_r = 1'b0;
  logic [4:0] cco_r = 5'd0;

  int checks = 0;
  int errors = 0;
  int cvi_cnt = 0;
  bit model_err = 1'b0;

  enigma_ctrl_if bif();

  enigma_ctrl #(.LEN_W(8), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .bus(bif)
  );

  always #5 clk = ~clk;

  // Cipher core stand-in: shift-by-one alphabet, 1-cycle latency, can be silenced.
  always @(posedge clk) begin
    cvo_r <= core_en && (bif.core_valid_in === 1'b1);
    cco_r <= (bif.core_char_in >= 5'd25) ? 5'd0 : bif.core_char_in + 5'd1;
  end
  assign bif.core_valid_out = cvo_r | stray;
  assign bif.core_char_out  = stray ? stray_char : cco_r;

  always @(negedge clk) if (bif.core_valid_in === 1'b1) cvi_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    msg_len = 8'(len);
    tick;
    start     = 1'b0;
    model_err = 1'b0;
    if (len == 0) begin
      chk("zl_done", done, 1);
      chk("zl_vld", bif.out_valid, 0);
      chk("zl_err", err, 0);
      tick;
      chk("zl_done_end", done, 0);
      chk("zl_busy_end", busy, 0);
    end else begin
      chk("st_busy", busy, 1);
      chk("st_err", err, 0);
      chk("st_rdy", bif.in_ready, 1);
    end
  endtask

  task automatic send_char(input logic [4:0] c, input bit last, input int stall, input bit poke);
    int n;
    int exp_c;
    int lat;
    if (c > 5'd25) begin
      exp_c = int'(c); lat = 1; model_err = 1'b1;
    end else if (core_en) begin
      exp_c = (int'(c) + 1) % 26; lat = 3;
    end else begin
      exp_c = int'(c); lat = 2 + WAIT_MAX; model_err = 1'b1;
    end
    bif.out_ready = (stall == 0);
    bif.in_valid  = 1'b1;
    bif.in_char   = c;
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 50) begin tick; n++; end
    chk("in_ready", bif.in_ready, 1);
    tick;
    bif.in_valid = 1'b0;
    bif.in_char  = 5'($urandom);
    if (poke) begin start = 1'b1; msg_len = 8'd1; end
    if (c <= 5'd25) begin
      chk("issue_vld", bif.core_valid_in, 1);
      chk("issue_char", bif.core_char_in, c);
    end
    n = 1;
    while (bif.out_valid !== 1'b1 && n < 50) begin tick; n++; end
    start = 1'b0;
    chk("latency", n, lat);
    chk("out_char", bif.out_char, exp_c);
    chk("out_last", bif.out_last, last);
    chk("err", err, model_err);
    chk("emit_rdy", bif.in_ready, 0);
    for (int k = 0; k < stall; k++) begin
      stray      = (k == 0);
      stray_char = 5'(exp_c + 3);
      tick;
      stray = 1'b0;
      chk("stall_vld", bif.out_valid, 1);
      chk("stall_char", bif.out_char, exp_c);
      chk("stall_last", bif.out_last, last);
      chk("stall_rdy", bif.in_ready, 0);
    end
    bif.out_ready = 1'b1;
    tick;
    chk("post_vld", bif.out_valid, 0);
    if (last) begin
      chk("done_pulse", done, 1);
      tick;
      chk("done_end", done, 0);
      chk("busy_end", busy, 0);
    end else begin
      chk("next_fetch", bif.in_ready, 1);
      chk("no_done", done, 0);
    end
  endtask

  task automatic run_msg(input int len, input bit allow_byp, input int stall_max, input bit poke);
    int base;
    int ncore;
    logic [4:0] c;
    do_start(len);
    base  = cvi_cnt;
    ncore = 0;
    for (int i = 0; i < len; i++) begin
      c = allow_byp ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 25));
      if (c <= 5'd25) ncore++;
      send_char(c, i == len - 1, $urandom_range(0, stall_max), poke && i == 0);
    end
    chk("core_issues", cvi_cnt - base, ncore);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int base;
    bif.in_valid  = 1'b0;
    bif.in_char   = 5'd0;
    bif.out_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_rdy", bif.in_ready, 0);
    chk("rst_out_vld", bif.out_valid, 0);
    chk("rst_out_char", bif.out_char, 0);
    chk("rst_out_last", bif.out_last, 0);
    chk("rst_core_vld", bif.core_valid_in, 0);
    chk("rst_core_char", bif.core_char_in, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    // basic message through the core
    do_start(3);
    base = cvi_cnt;
    send_char(5'd0, 1'b0, 0, 1'b0);
    send_char(5'd7, 1'b0, 0, 1'b0);
    send_char(5'd25, 1'b1, 0, 1'b0);
    chk("basic_issues", cvi_cnt - base, 3);
    chk("basic_err", err, 0);

    // backpressure on the first result
    do_start(2);
    send_char(5'd4, 1'b0, 5, 1'b0);
    send_char(5'd5, 1'b1, 0, 1'b0);

    // bypass code then a normal one
    do_start(2);
    base = cvi_cnt;
    send_char(5'd30, 1'b0, 0, 1'b0);
    send_char(5'd2, 1'b1, 0, 1'b0);
    chk("byp_issues", cvi_cnt - base, 1);
    chk("byp_err_sticky", err, 1);

    // zero-length message clears err and only pulses done
    do_start(0);

    // silent core trips the watchdog
    core_en = 1'b0;
    do_start(1);
    send_char(5'd9, 1'b1, 0, 1'b0);
    chk("wd_err_sticky", err, 1);
    core_en = 1'b1;

    // start pulsed mid-message must not reload the count
    run_msg(3, 1'b0, 0, 1'b1);

    // abort while waiting on the core
    do_start(3);
    send_char(5'd30, 1'b0, 0, 1'b0);
    core_en      = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_char  = 5'd5;
    tick;
    bif.in_valid = 1'b0;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_vld", bif.out_valid, 0);
    chk("ab_core_vld", bif.core_valid_in, 0);
    chk("ab_err_kept", err, 1);
    core_en    = 1'b1;
    stray      = 1'b1;
    stray_char = 5'd7;
    tick;
    stray = 1'b0;
    tick;
    chk("late_busy", busy, 0);
    chk("late_vld", bif.out_valid, 0);
    chk("late_done", done, 0);
    abort   = 1'b1;
    start   = 1'b1;
    msg_len = 8'd2;
    tick;
    abort = 1'b0;
    start = 1'b0;
    chk("ab_over_start", busy, 0);

    // longest message must not wrap the count
    run_msg(255, 1'b0, 0, 1'b0);

    for (int m = 0; m < 8; m++) begin
      core_en = ($urandom_range(0, 3) != 0);
      run_msg($urandom_range(1, 6), 1'b1, 3, m == 2);
    end
    core_en = 1'b1;

    // asynchronous reset while a result is waiting
    do_start(2);
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_char   = 5'd31;
    tick;
    bif.in_valid = 1'b0;
    chk("pre_rst_vld", bif.out_valid, 1);
    chk("pre_rst_err", err, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", bif.out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_char", bif.out_char, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
